uart_tx_frame: RTL and testbench

- Parametrised successor to the fixed 8N1 UART transmitter.
- Data width, parity mode and stop-bit count are set at elaboration.
- Adds a one-entry holding register with ready/valid acceptance, so consecutive frames go out back-to-back with zero idle gap.
- Sits between a byte producer (command/packet formatter) and the FPGA TX pin.

---
 rtl/uart_tx_frame.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: configurable data width, parity and stop bits,
// with a one-entry holding register so frames can be sent back-to-back.
module uart_tx_frame #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 tx_dv_i,
    input  logic [DATA_BITS-1:0] tx_byte_i,
    output logic                 tx_ready_o,
    output logic                 tx_active_o,
    output logic                 tx_serial_o,
    output logic                 tx_done_o
);

    localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
    localparam int unsigned     IdxW     = 4;
    localparam logic [IdxW-1:0] DataLast = IdxW'(DATA_BITS - 1);
    localparam logic [IdxW-1:0] StopLast = IdxW'(STOP_BITS - 1);

    // Reject illegal configurations at elaboration.
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
        $error("uart_tx_frame: CLKS_PER_BIT must be in 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
    logic                 bit_end;
    logic                 load;

    // Next-state logic: bit timing, frame sequencing and holding-register handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_d        = par_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        serial_d     = serial_q;
        active_d     = active_q;
        done_d       = 1'b0;
        load         = 1'b0;
        bit_end      = (cnt_q == CntMax);

        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                serial_d = 1'b1;
                cnt_d    = '0;
                if (hold_valid_q) begin
                    load = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d  = StData;
                    idx_d    = '0;
                    serial_d = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == DataLast) begin
                        if (PARITY_MODE != 0) begin
                            state_d  = StParity;
                            serial_d = par_q;
                        end else begin
                            state_d  = StStop;
                            idx_d    = '0;
                            serial_d = 1'b1;
                        end
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        shift_d  = shift_q >> 1;
                        serial_d = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d  = StStop;
                    idx_d    = '0;
                    serial_d = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (idx_q == StopLast) begin
                        done_d = 1'b1;
                        if (hold_valid_q) begin
                            // Chain straight into the next frame with no idle gap.
                            load = 1'b1;
                        end else begin
                            state_d  = StIdle;
                            active_d = 1'b0;
                            serial_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                serial_d = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
                idx_d    = '0;
            end
        endcase

        if (load) begin
            state_d  = StStart;
            shift_d  = hold_q;
            // Odd parity inverts the XOR so the total count of ones is odd.
            par_d    = (^hold_q) ^ (PARITY_MODE == 1);
            serial_d = 1'b0;
            active_d = 1'b1;
            cnt_d    = '0;
            idx_d    = '0;
        end

        // Load and acceptance are mutually exclusive: load needs a full hold, acceptance an empty one.
        if (load) begin
            hold_valid_d = 1'b0;
        end else if (tx_dv_i && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_d       = tx_byte_i;
        end
    end

    // State and datapath registers; line idles high in reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            serial_q     <= 1'b1;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            serial_q     <= serial_d;
            active_q     <= active_d;
            done_q       <= done_d;
        end
    end

    assign tx_ready_o  = ~hold_valid_q;
    assign tx_active_o = active_q;
    assign tx_serial_o = serial_q;
    assign tx_done_o   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: several parameter sets run side by side, each checked
// every cycle against a frame-level model plus a literal first-frame pattern.
module tb_uart_tx_frame;

    localparam int NCFG = 5;
    localparam int CFG_C  [NCFG] = '{4, 3, 2, 5, 3};
    localparam int CFG_DB [NCFG] = '{8, 8, 8, 7, 8};
    localparam int CFG_PM [NCFG] = '{0, 2, 1, 0, 1};
    localparam int CFG_SB [NCFG] = '{1, 1, 2, 2, 1};
    localparam int CFG_W  [NCFG] = '{'hA5, 'h07, 'h00, 'h7F, 'h07};
    // Line levels of the first frame, bit i = i-th bit period (start first).
    localparam logic [15:0] CFG_EXP [NCFG] =
        '{16'h034A, 16'h060E, 16'h0E00, 16'h03FE, 16'h040E};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    wire [NCFG-1:0] all_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int C    = CFG_C[g];
        localparam int DB   = CFG_DB[g];
        localparam int PM   = CFG_PM[g];
        localparam int SB   = CFG_SB[g];
        localparam int NB   = 1 + DB + ((PM != 0) ? 1 : 0) + SB;
        localparam int FLEN = NB * C;

        logic          rst_n;
        logic          dv;
        logic [DB-1:0] byte_in;
        logic          ready, active, serial, done;
        bit            fin;

        // Frame-level model state.
        bit            m_busy, m_hold_full, m_done, was_full, accept;
        int            m_cyc;
        logic [15:0]   m_frame;
        logic [DB-1:0] m_hold;
        logic          m_line;

        // Directed/random stimulus state.
        logic [15:0]   seq;
        int            n_act, n_done, mode;

        assign all_done[g] = fin;

        uart_tx_frame #(
            .CLKS_PER_BIT (C),
            .DATA_BITS    (DB),
            .PARITY_MODE  (PM),
            .STOP_BITS    (SB)
        ) u_dut (
            .clk_i       (clk),
            .rst_n_i     (rst_n),
            .tx_dv_i     (dv),
            .tx_byte_i   (byte_in),
            .tx_ready_o  (ready),
            .tx_active_o (active),
            .tx_serial_o (serial),
            .tx_done_o   (done)
        );

        // Frame as a list of line levels: start 0, data LSB first, parity, stop 1s.
        function automatic logic [15:0] frame_of(input logic [DB-1:0] w);
            logic [15:0] f;
            int          ones;
            f       = 16'hFFFF;
            f[0]    = 1'b0;
            f[DB:1] = w;
            ones    = $countones(w);
            if (PM == 2) f[DB+1] = (ones % 2 == 1);
            else if (PM == 1) f[DB+1] = (ones % 2 == 0);
            return f;
        endfunction

        // Model: a frame lasts FLEN cycles; the held word starts on the edge the line is free.
        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_hold_full = 0; m_done = 0; m_cyc = 0;
            end else begin
                accept   = dv && !m_hold_full;
                was_full = m_hold_full;
                m_done   = 0;
                if (m_busy) begin
                    m_cyc++;
                    if (m_cyc == FLEN) begin
                        m_done = 1;
                        m_busy = 0;
                    end
                end
                if (!m_busy && was_full) begin
                    m_busy      = 1;
                    m_cyc       = 0;
                    m_frame     = frame_of(m_hold);
                    m_hold_full = 0;
                end
                if (accept) begin
                    m_hold_full = 1;
                    m_hold      = byte_in;
                end
            end
        end

        // Per-cycle comparison of all outputs against the model.
        initial forever begin
            @(negedge clk);
            m_line = m_busy ? m_frame[4'(m_cyc / C)] : 1'b1;
            chk($sformatf("cfg%0d_serial", g), 32'(serial), 32'(m_line));
            chk($sformatf("cfg%0d_active", g), 32'(active), 32'(m_busy));
            chk($sformatf("cfg%0d_ready", g),  32'(ready),  32'(!m_hold_full));
            chk($sformatf("cfg%0d_done", g),   32'(done),   32'(m_done));
        end

        initial begin
            rst_n   = 1'b0;
            dv      = 1'b0;
            byte_in = '0;
            repeat (3) @(negedge clk);
            chk($sformatf("cfg%0d_rst_serial", g), 32'(serial), 32'd1);
            chk($sformatf("cfg%0d_rst_ready", g),  32'(ready),  32'd1);
            chk($sformatf("cfg%0d_rst_active", g), 32'(active), 32'd0);
            rst_n = 1'b1;
            @(negedge clk);

            // Directed first frame with hand-computed line pattern.
            dv      = 1'b1;
            byte_in = DB'(CFG_W[g]);
            @(negedge clk);
            dv = 1'b0;
            chk($sformatf("cfg%0d_pre_start", g), 32'(serial), 32'd1);
            chk($sformatf("cfg%0d_held", g),      32'(ready),  32'd0);
            seq    = '0;
            n_act  = 0;
            n_done = 0;
            for (int c = 0; c < FLEN + 4; c++) begin
                @(negedge clk);
                if (c == 0) chk($sformatf("cfg%0d_start_latency", g), 32'(serial), 32'd0);
                if (c < FLEN && (c % C) == C / 2) seq[4'(c / C)] = serial;
                n_act  += int'(active);
                n_done += int'(done);
            end
            chk($sformatf("cfg%0d_frame_bits", g), 32'(seq), 32'(CFG_EXP[g]));
            chk($sformatf("cfg%0d_active_cycles", g), n_act, FLEN);
            chk($sformatf("cfg%0d_done_pulses", g), n_done, 1);

            // Random traffic: sparse, continuous (back-to-back, hold full) and mixed.
            mode = 0;
            for (int c = 0; c < 1500; c++) begin
                if (c % 150 == 0) mode = int'($urandom_range(0, 2));
                case (mode)
                    0:       dv = ($urandom_range(0, 15) == 0);
                    1:       dv = 1'b1;
                    default: dv = 1'($urandom_range(0, 1));
                endcase
                byte_in = DB'($urandom);
                @(negedge clk);
            end

            // Reset in the middle of an all-zero data field with a second word held.
            dv = 1'b0;
            repeat (2 * FLEN + 4) @(negedge clk);
            dv      = 1'b1;
            byte_in = '0;
            @(negedge clk);
            byte_in = DB'($urandom);
            repeat (2) @(negedge clk);
            dv = 1'b0;
            repeat (2 * C) @(negedge clk);
            chk($sformatf("cfg%0d_pre_rst_line", g),   32'(serial), 32'd0);
            chk($sformatf("cfg%0d_pre_rst_active", g), 32'(active), 32'd1);
            @(posedge clk);
            #1 rst_n = 1'b0;
            #1;
            chk($sformatf("cfg%0d_mid_rst_serial", g), 32'(serial), 32'd1);
            chk($sformatf("cfg%0d_mid_rst_active", g), 32'(active), 32'd0);
            chk($sformatf("cfg%0d_mid_rst_ready", g),  32'(ready),  32'd1);
            chk($sformatf("cfg%0d_mid_rst_done", g),   32'(done),   32'd0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(negedge clk);

            // Clean frame after reset.
            dv      = 1'b1;
            byte_in = DB'($urandom);
            @(negedge clk);
            dv = 1'b0;
            repeat (FLEN + 6) @(negedge clk);
            fin = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 20000; t++) begin
            @(posedge clk);
            if (&all_done) break;
        end
        chk("all_configs_finished", 32'(all_done), 32'((1 << NCFG) - 1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
